// File: rtl/hist_stat_ctrl.sv
// ----------------------------------------------------------------------------
// hist_stat_ctrl: per-frame statistics sequencer for the ping-pong histogram
// RAM. Each frame_end flips the RAM banks, then reads the completed (backup)
// bank twice: once to sum the bins and the bin-weighted counts, and once more
// to find the median bin. The mean comes from an iterative divider.
// Results appear together with a one-cycle stat_valid strobe.
//
// Ports
//   clk                system clock (also hist_ram in_clk / out_clk)
//   rst                synchronous, active-high reset
//   frame_end          one-cycle end-of-frame pulse
//   hist_flip_trigger  bank flip request to hist_ram, high FLIP_CYC cycles
//   hist_out_en        hist_ram read enable
//   hist_out_addr      hist_ram read address
//   hist_out_data      hist_ram read data, valid one cycle after the address
//   busy               high whenever the sequencer is not idle
//   stat_valid         one-cycle pulse when stat_* are updated
//   stat_total         sum of all bins
//   stat_mean          floor(sum(bin*count) / total)
//   stat_median        lowest bin b with 2*cum(0..b) >= total
//   overrun            one-cycle pulse: frame_end arrived while busy (dropped)
//
// shift_div (same file): restoring shift-subtract divider, one quotient bit
// per cycle. Inputs are captured on en; done pulses when c holds a/b.
// Ports: clk, rst_n (synchronous, active-low), en, a, b, c, done.
// ----------------------------------------------------------------------------

module shift_div #(
    parameter int BITS = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic [BITS-1:0] a,
    input  logic [BITS-1:0] b,
    output logic [BITS-1:0] c,
    output logic            done
);
    localparam int CW = $clog2(BITS + 1);

    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [BITS-1:0] rem_q, rem_d;
    logic [BITS-1:0] quo_q, quo_d;
    logic [BITS-1:0] den_q, den_d;
    logic [BITS:0]   shifted;
    logic [BITS-1:0] diff;

    // NOTE: every variable assigned in always_comb gets a default first, so no
    // path through the case/if tree can leave it unassigned and infer a latch.
    always_comb begin
        busy_d  = busy_q;
        done_d  = 1'b0;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        den_d   = den_q;
        shifted = {rem_q, quo_q[BITS-1]};
        // The true difference is below den, so modulo-2^BITS arithmetic
        // yields the exact remainder.
        diff    = shifted[BITS-1:0] - den_q;

        if (busy_q) begin
            if (shifted >= {1'b0, den_q}) begin
                rem_d = diff;
                quo_d = {quo_q[BITS-2:0], 1'b1};
            end else begin
                rem_d = shifted[BITS-1:0];
                quo_d = {quo_q[BITS-2:0], 1'b0};
            end
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CW'(1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end else if (en) begin
            busy_d = 1'b1;
            cnt_d  = CW'(BITS);
            rem_d  = '0;
            quo_d  = a;
            den_d  = b;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
            cnt_q  <= '0;
            rem_q  <= '0;
            quo_q  <= '0;
            den_q  <= '0;
        end else begin
            busy_q <= busy_d;
            done_q <= done_d;
            cnt_q  <= cnt_d;
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            den_q  <= den_d;
        end
    end

    assign c    = quo_q;
    assign done = done_q;
endmodule

module hist_stat_ctrl #(
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 24,
    parameter int FLIP_CYC  = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           frame_end,
    output logic                           hist_flip_trigger,
    output logic                           hist_out_en,
    output logic [ADDR_BITS-1:0]           hist_out_addr,
    input  logic [DATA_BITS-1:0]           hist_out_data,
    output logic                           busy,
    output logic                           stat_valid,
    output logic [DATA_BITS+ADDR_BITS-1:0] stat_total,
    output logic [ADDR_BITS-1:0]           stat_mean,
    output logic [ADDR_BITS-1:0]           stat_median,
    output logic                           overrun
);
    localparam int TW = DATA_BITS + ADDR_BITS;      // total / cumulative width
    localparam int WW = DATA_BITS + 2 * ADDR_BITS;  // weighted-sum width
    localparam int FW = (FLIP_CYC > 1) ? $clog2(FLIP_CYC) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FLIP,
        S_SUM,
        S_SEARCH,
        S_DIV_START,
        S_DIV_WAIT,
        S_DONE,
        S_DONE_ZERO
    } state_t;

    state_t               state_q, state_d;
    logic [FW-1:0]        flip_cnt_q, flip_cnt_d;
    logic [ADDR_BITS:0]   cnt_q, cnt_d;        // MSB set = all NB addresses issued
    logic                 rd_vld_q, rd_vld_d;  // hist_out_data carries a requested bin
    logic [ADDR_BITS-1:0] a_d_q, a_d_d;        // address of the bin on hist_out_data
    logic [TW-1:0]        tot_q, tot_d;
    logic [WW-1:0]        wsum_q, wsum_d;
    logic [TW-1:0]        cum_q, cum_d;
    logic [ADDR_BITS-1:0] med_q, med_d;
    logic                 stat_valid_q, stat_valid_d;
    logic [TW-1:0]        stat_total_q, stat_total_d;
    logic [ADDR_BITS-1:0] stat_mean_q, stat_mean_d;
    logic [ADDR_BITS-1:0] stat_median_q, stat_median_d;
    logic                 overrun_q, overrun_d;

    logic                 div_en;
    logic [WW-1:0]        div_c;
    logic                 div_done;
    logic [TW-1:0]        cum_new;
    logic [TW-1:0]        prod;
    logic                 hit;

    shift_div #(.BITS(WW)) u_div (
        .clk   (clk),
        .rst_n (~rst),
        .en    (div_en),
        .a     (wsum_q),
        .b     ({{ADDR_BITS{1'b0}}, tot_q}),
        .c     (div_c),
        .done  (div_done)
    );

    always_comb begin
        state_d       = state_q;
        flip_cnt_d    = flip_cnt_q;
        cnt_d         = cnt_q;
        tot_d         = tot_q;
        wsum_d        = wsum_q;
        cum_d         = cum_q;
        med_d         = med_q;
        stat_valid_d  = 1'b0;
        stat_total_d  = stat_total_q;
        stat_mean_d   = stat_mean_q;
        stat_median_d = stat_median_q;
        overrun_d     = frame_end && (state_q != S_IDLE);

        hist_flip_trigger = 1'b0;
        hist_out_en       = 1'b0;
        hist_out_addr     = '0;
        div_en            = 1'b0;
        busy              = (state_q != S_IDLE);

        cum_new = cum_q + TW'(hist_out_data);
        prod    = TW'(a_d_q) * TW'(hist_out_data);
        hit     = rd_vld_q && ({cum_new, 1'b0} >= {1'b0, tot_q});

        case (state_q)
            S_IDLE: begin
                if (frame_end) begin
                    state_d    = S_FLIP;
                    flip_cnt_d = '0;
                end
            end

            S_FLIP: begin
                hist_flip_trigger = 1'b1;
                tot_d  = '0;
                wsum_d = '0;
                cum_d  = '0;
                cnt_d  = '0;
                if (flip_cnt_q == FW'(FLIP_CYC - 1)) begin
                    state_d = S_SUM;
                end else begin
                    flip_cnt_d = flip_cnt_q + 1'b1;
                end
            end

            S_SUM: begin
                // Issue NB reads, then one drain cycle (en low) that absorbs
                // the data of the last bin before moving on.
                hist_out_addr = cnt_q[ADDR_BITS-1:0];
                hist_out_en   = !cnt_q[ADDR_BITS];
                if (hist_out_en) begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (rd_vld_q) begin
                    tot_d  = tot_q + TW'(hist_out_data);
                    wsum_d = wsum_q + WW'(prod);
                end
                if (cnt_q[ADDR_BITS]) begin
                    state_d = S_SEARCH;
                    cnt_d   = '0;
                end
            end

            S_SEARCH: begin
                hist_out_addr = cnt_q[ADDR_BITS-1:0];
                if (tot_q == '0) begin
                    stat_valid_d  = 1'b1;
                    stat_total_d  = '0;
                    stat_mean_d   = '0;
                    stat_median_d = '0;
                    state_d       = S_DONE_ZERO;
                end else begin
                    // Read enable drops in the very cycle the hit bin returns,
                    // so no read is issued past the median address.
                    hist_out_en = !cnt_q[ADDR_BITS] && !hit;
                    if (hist_out_en) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    if (hit) begin
                        med_d   = a_d_q;
                        state_d = S_DIV_START;
                    end else if (rd_vld_q) begin
                        cum_d = cum_new;
                    end else if (cnt_q[ADDR_BITS]) begin
                        // Unreachable when tot is non-zero (bin NB-1 always
                        // hits); keeps the FSM from stalling regardless.
                        med_d   = '1;
                        state_d = S_DIV_START;
                    end
                end
            end

            S_DIV_START: begin
                div_en  = 1'b1;
                state_d = S_DIV_WAIT;
            end

            S_DIV_WAIT: begin
                if (div_done) begin
                    stat_valid_d  = 1'b1;
                    stat_total_d  = tot_q;
                    // The quotient is always below NB; saturate defensively.
                    stat_mean_d   = (|div_c[WW-1:ADDR_BITS]) ? '1
                                                              : div_c[ADDR_BITS-1:0];
                    stat_median_d = med_q;
                    state_d       = S_DONE;
                end
            end

            S_DONE, S_DONE_ZERO: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Pipeline tracking of reads: data returns one cycle after the address.
    assign rd_vld_d = hist_out_en;
    assign a_d_d    = hist_out_addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            flip_cnt_q    <= '0;
            cnt_q         <= '0;
            rd_vld_q      <= 1'b0;
            a_d_q         <= '0;
            tot_q         <= '0;
            wsum_q        <= '0;
            cum_q         <= '0;
            med_q         <= '0;
            stat_valid_q  <= 1'b0;
            stat_total_q  <= '0;
            stat_mean_q   <= '0;
            stat_median_q <= '0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            flip_cnt_q    <= flip_cnt_d;
            cnt_q         <= cnt_d;
            rd_vld_q      <= rd_vld_d;
            a_d_q         <= a_d_d;
            tot_q         <= tot_d;
            wsum_q        <= wsum_d;
            cum_q         <= cum_d;
            med_q         <= med_d;
            stat_valid_q  <= stat_valid_d;
            stat_total_q  <= stat_total_d;
            stat_mean_q   <= stat_mean_d;
            stat_median_q <= stat_median_d;
            overrun_q     <= overrun_d;
        end
    end

    assign stat_valid  = stat_valid_q;
    assign stat_total  = stat_total_q;
    assign stat_mean   = stat_mean_q;
    assign stat_median = stat_median_q;
    assign overrun     = overrun_q;
endmodule

// File: doc/hist_stat_ctrl.md
Name: hist_stat_ctrl

Overview:
- Per-frame statistics sequencer for the ping-pong histogram RAM (hist_ram) used by AE/AWB.
- On each frame end it pulses hist_ram's flip trigger, then reads the just-completed (backup) bank.
- From that bank it computes the pixel total, the mean bin (via an internal shift_div instance) and the median bin.
- It publishes the results with a one-cycle valid strobe to the register/AE logic.

Parameters:
ADDR_BITS  8   histogram bin address width; number of bins NB = 2**ADDR_BITS
DATA_BITS  24  per-bin count width (matches hist_ram DATA_BITS)
FLIP_CYC   2   cycles hist_flip_trigger is held high (≥1)

Ports:
clk               input   1                    system clock; also drives hist_ram in_clk and out_clk
rst               input   1                    synchronous, active-high reset
frame_end         input   1                    one-cycle pulse at end of frame
hist_flip_trigger output  1                    to hist_ram in_flip_trigger
hist_out_en       output  1                    to hist_ram out_en
hist_out_addr     output  ADDR_BITS            to hist_ram out_addr
hist_out_data     input   DATA_BITS            from hist_ram out_data; 1-cycle read latency
busy              output  1                    high in every state except IDLE
stat_valid        output  1                    one-cycle pulse, results updated
stat_total        output  DATA_BITS+ADDR_BITS  sum of all bins
stat_mean         output  ADDR_BITS            floor(sum(bin*count)/total)
stat_median       output  ADDR_BITS            lowest bin b with 2*cum(0..b) >= total
overrun           output  1                    one-cycle pulse, frame_end ignored while busy

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high. All state updates on posedge clk.
- Reset values: hist_flip_trigger=0, hist_out_en=0, hist_out_addr=0, busy=0, stat_valid=0, stat_total=0, stat_mean=0, stat_median=0, overrun=0; FSM=IDLE; accumulators=0.
- Reset mid-operation: returns to IDLE next cycle and drops the frame; outputs take reset values.
- The internal shift_div uses active-low reset, driven by ~rst.
- Internal widths:
  - tot accumulator: DATA_BITS+ADDR_BITS.
  - wsum accumulator: DATA_BITS+2*ADDR_BITS.
  - shift_div BITS = DATA_BITS+2*ADDR_BITS; b operand = zero-extended tot. No overflow is possible.
- FSM states:
  - IDLE: on frame_end go to FLIP; busy=1 from next cycle.
  - FLIP: hist_flip_trigger=1 for exactly FLIP_CYC cycles, then 0; go to SUM. Clear tot, wsum, cum, and the bin counter.
  - SUM: hist_out_en=1; hist_out_addr steps 0..NB-1, one per cycle. Data for address a arrives next cycle (registered a_d). Accumulate tot+=data and wsum+=a_d*data. After the last address, one drain cycle (en=0) absorbs bin NB-1; then go to SEARCH. SUM duration = NB+1 cycles.
  - SEARCH: if tot==0, set median=0 and go to DONE_ZERO. Otherwise stream addresses 0..NB-1 again, cum+=data. On the first returned bin where 2*cum_new >= tot, latch median = that bin, drop en, and go to DIV_START. In-flight data after the hit is discarded. The hit is guaranteed by bin NB-1.
  - DIV_START: shift_div enable=1 for one cycle with a=wsum, b=tot; go to DIV_WAIT.
  - DIV_WAIT: wait for shift_div done. Then stat_mean = c[ADDR_BITS-1:0] (quotient < NB guaranteed); go to DONE.
  - DONE: stat_total=tot, stat_mean, and stat_median all update on the same edge that stat_valid=1 (one cycle); go to IDLE.
  - DONE_ZERO: same as DONE with stat_mean=0, stat_median=0, stat_total=0.
- Result outputs hold their values between stat_valid pulses.
- frame_end in any state other than IDLE: ignored and overrun=1 for one cycle. frame_end in the same cycle DONE→IDLE is also ignored (FSM not yet IDLE).
- Only the backup bank is read. The active bank keeps accumulating the new frame concurrently.

Test Plan:
- Uniform histogram, NB=256, every bin=1: frame_end → stat_valid with total=256, mean=127, median=127. No overrun.
- Single populated bin 200 with count 5000: total=5000, mean=200, median=200. hist_out_addr in SEARCH stops at 200.
- Empty frame (all bins 0): stat_valid with total=0, mean=0, median=0. No shift_div enable observed.
- Bin0=3 and bin255=3: median=0 (2*3 >= 6), mean=127 (765/6=127). Bin0=2 and bin255=3: median=255.
- Second frame_end during SUM → overrun pulse, no second flip, single stat_valid. Next frame_end after busy falls is processed normally.
- Assert rst for one cycle mid-SUM: next cycle busy=0, en=0, trigger=0, no stat_valid. A following frame_end produces correct results.
